uart_rx_frame_ctrl: RTL
=======================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, the maximum payload bytes per frame (range 1..16).
REQ-003 SHALL have parameter TIMEOUT, default 2000, the inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iData  input  8  received byte from the UART receiver.
REQ-007 SHALL have port iValid  input  1  receiver byte strobe; may stay high for several cycles per byte.
REQ-008 SHALL have port iRdAddr  input  4  payload buffer read address.
REQ-009 SHALL have port oRdData  output  8  payload byte at iRdAddr, combinational read.
REQ-010 SHALL have port oLen  output  5  payload length of the last good frame.
REQ-011 SHALL have port oFrameValid  output  1  one-cycle pulse when a good frame completes.
REQ-012 SHALL have port oErrCsum, oErrLen, oErrTimeout  output  1 each  one-cycle error pulses.
REQ-013 SHALL have port oAbort  output  1  abort request to the receiver, drives its rstTx input.
REQ-014 SHALL have port oBusy  output  1  high in every state except IDLE.
REQ-015 SHALL have port oFrameCnt  output  8  count of good frames, wraps 255->0.

Function
REQ-016 SHALL define a byte event as the rising edge of iValid, using a registered copy of iValid; a multi-cycle high iValid SHALL count as exactly one byte.
REQ-017 SHALL implement the states IDLE, LEN, PAYLOAD and CSUM.
REQ-018 SHALL, in IDLE on a byte event with iData==SYNC_BYTE, go to LEN; any other byte in IDLE is ignored.
REQ-019 SHALL, in LEN on a byte event, check the length byte: if 1<=iData<=MAX_LEN, latch the length, set the running checksum to iData, clear the write index and go to PAYLOAD; otherwise pulse oErrLen and go to IDLE.
REQ-020 SHALL, in PAYLOAD on each byte event, write iData to buffer[index], add iData to the checksum mod 256 and increment the index; after the byte where index reaches the length, go to CSUM.
REQ-021 SHALL, in CSUM on a byte event, compare iData to the checksum: on match, pulse oFrameValid, update oLen, increment oFrameCnt and go to IDLE; on mismatch, pulse oErrCsum, leave oLen unchanged and go to IDLE.
REQ-022 SHALL assert outputs oFrameValid, oErrCsum and oErrLen in the cycle after the qualifying byte event (latency 1 cycle from the detected edge).
REQ-023 SHALL, in LEN, PAYLOAD and CSUM, count clk cycles since the last byte event; the counter clears on every byte event and on entry to a state.
REQ-024 SHALL, when the counter reaches TIMEOUT-1, pulse oErrTimeout, hold oAbort high for exactly 4 cycles and go to IDLE.
REQ-025 SHALL give a byte event priority over a timeout in the same cycle: the byte is processed and the counter is cleared.
REQ-026 SHALL ignore byte events while oAbort is high.
REQ-027 SHALL write the buffer in place with no double buffering: oRdData is stable from oFrameValid until the next frame's first payload byte.
REQ-028 SHALL leave buffer contents unchanged on error or timeout; bytes already written by the aborted frame remain.
REQ-029 SHALL keep a checksum register 8 bits wide, with the carry discarded.

Reset
REQ-030 SHALL, while reset is low, force state=IDLE and clear the timeout counter, checksum, index and registered iValid.
REQ-031 SHALL, while reset is low, force oLen=0, oFrameCnt=0, and oFrameValid, oErrCsum, oErrLen, oErrTimeout, oAbort and oBusy to 0.
REQ-032 SHALL leave buffer contents undefined after reset and SHALL NOT reset them.
REQ-033 SHALL, on reset asserted mid-frame, abandon the frame without any error pulse.

Verification
REQ-034 SHALL cover a good frame: bytes A5,03,11,22,33,69 (iValid high 3 cycles each) -> one oFrameValid pulse, oLen=3, buffer[0..2]=11,22,33, oFrameCnt=1.
REQ-035 SHALL cover a bad checksum: A5,02,10,20,00 -> oErrCsum pulse, no oFrameValid, oLen and oFrameCnt unchanged.
REQ-036 SHALL cover bad lengths: A5,00 -> oErrLen; A5,11 with MAX_LEN=16 -> oErrLen; both end in IDLE.
REQ-037 SHALL cover a timeout: A5,04,01, then no bytes for TIMEOUT cycles -> oErrTimeout pulse, oAbort high 4 cycles, oBusy=0, and a later good frame is accepted.
REQ-038 SHALL cover noise and an edge case: bytes 00,FF,5A before A5,01,7E,7F -> frame accepted with oLen=1; a byte edge in the same cycle as TIMEOUT-1 -> no timeout.
REQ-039 SHALL cover reset mid-frame: reset low after A5,05,AA -> all outputs 0, and the next A5,01,01,02 produces oFrameValid.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : Frames bytes from a UART receiver as
//               SYNC, LEN, payload[LEN], CSUM (CSUM = LEN + sum(payload) mod
//               256). Stores the payload in place, reports good frames and
//               length/checksum/inter-byte timeout errors, and requests a
//               receiver abort after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iData,
  input  logic       iValid,
  input  logic [3:0] iRdAddr,
  output logic [7:0] oRdData,
  output logic [4:0] oLen,
  output logic       oFrameValid,
  output logic       oErrCsum,
  output logic       oErrLen,
  output logic       oErrTimeout,
  output logic       oAbort,
  output logic       oBusy,
  output logic [7:0] oFrameCnt
);

  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]      LEN_MAX   = 8'(MAX_LEN);
  localparam logic [2:0]      ABORT_CYC = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ivalid_q;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       csum_q, csum_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       len_q, len_d;
  logic [4:0]       olen_q, olen_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             fv_q, fv_d;
  logic             err_csum_q, err_csum_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;
  logic [2:0]       abort_cnt_q, abort_cnt_d;

  logic             byte_ev;
  logic             buf_we;
  logic [3:0]       buf_waddr;
  logic [7:0]       buf_mem [0:15];

  // A byte is the rising edge of the strobe; edges during an abort are dropped.
  assign byte_ev = iValid & ~ivalid_q & (abort_cnt_q == 3'd0);

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    len_d       = len_q;
    olen_d      = olen_q;
    frame_cnt_d = frame_cnt_q;
    fv_d        = 1'b0;
    err_csum_d  = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    abort_cnt_d = (abort_cnt_q != 3'd0) ? abort_cnt_q - 3'd1 : 3'd0;
    buf_we      = 1'b0;
    buf_waddr   = idx_q[3:0];
    // Busy states only; every entry into a busy state comes from a byte event.
    tmo_cnt_d   = (state_q == IDLE || byte_ev) ? '0 : tmo_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (byte_ev && iData == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (byte_ev) begin
          if (iData != 8'd0 && iData <= LEN_MAX) begin
            len_d   = iData[4:0];
            csum_d  = iData;
            idx_d   = 5'd0;
            state_d = PAYLOAD;
          end else begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (byte_ev) begin
          buf_we = 1'b1;
          csum_d = csum_q + iData;
          idx_d  = idx_q + 5'd1;
          if (idx_q + 5'd1 == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (byte_ev) begin
          if (iData == csum_q) begin
            fv_d        = 1'b1;
            olen_d      = len_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_csum_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving on the last counted cycle wins over the timeout.
    if (state_q != IDLE && !byte_ev && tmo_cnt_q == TMO_LAST) begin
      state_d     = IDLE;
      err_tmo_d   = 1'b1;
      abort_cnt_d = ABORT_CYC;
      tmo_cnt_d   = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ivalid_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      csum_q      <= 8'd0;
      idx_q       <= 5'd0;
      len_q       <= 5'd0;
      olen_q      <= 5'd0;
      frame_cnt_q <= 8'd0;
      fv_q        <= 1'b0;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      abort_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      ivalid_q    <= iValid;
      tmo_cnt_q   <= tmo_cnt_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      olen_q      <= olen_d;
      frame_cnt_q <= frame_cnt_d;
      fv_q        <= fv_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  // Payload buffer, written in place and deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_waddr] <= iData;
  end

  assign oRdData     = buf_mem[iRdAddr];
  assign oLen        = olen_q;
  assign oFrameValid = fv_q;
  assign oErrCsum    = err_csum_q;
  assign oErrLen     = err_len_q;
  assign oErrTimeout = err_tmo_q;
  assign oAbort      = (abort_cnt_q != 3'd0);
  assign oBusy       = (state_q != IDLE);
  assign oFrameCnt   = frame_cnt_q;

endmodule
`default_nettype wire
